// File: rtl/div_if.sv
// ---------------------------------------------------------------------------
// div_if -- handshake/result bundle between the sequential divider and its
// requester.
//
// Signals:
//   divStart  requester -> divider  start request (sampled in IDLE only)
//   dividend  requester -> divider  32-bit signed dividend
//   divisor   requester -> divider  32-bit signed divisor
//   divBusy   divider -> requester  division in progress
//   divDone   divider -> requester  one-cycle result-valid pulse
//   DivtoHI   divider -> requester  remainder (HI path)
//   DivtoLO   divider -> requester  quotient (LO path)
//   divZero   divider -> requester  divisor-was-zero flag
//
// Modports: master = requester side, slave = divider side.
// ---------------------------------------------------------------------------
interface div_if;
    logic        divStart;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        divBusy;
    logic        divDone;
    logic [31:0] DivtoHI;
    logic [31:0] DivtoLO;
    logic        divZero;

    modport master (
        output divStart, dividend, divisor,
        input  divBusy, divDone, DivtoHI, DivtoLO, divZero
    );

    modport slave (
        input  divStart, dividend, divisor,
        output divBusy, divDone, DivtoHI, DivtoLO, divZero
    );
endinterface

// File: rtl/div_seq.sv
// ---------------------------------------------------------------------------
// div_seq -- 32-bit signed sequential divider, one restoring step per cycle.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bus    div_if.slave: divStart/dividend/divisor in,
//          divBusy/divDone/DivtoHI(remainder)/DivtoLO(quotient)/divZero out
//
// Sequence: IDLE -> RUN (32 steps) -> FIX (sign correction, load outputs)
//           -> DONE (divDone pulse) -> IDLE.
//
// Build option DIV_ZERO_EXC_EN: when defined, a zero divisor goes straight
// from IDLE to DONE with DivtoHI=dividend, DivtoLO=0, divZero=1. When not
// defined, a zero divisor runs the normal iteration (magnitude quotient
// all-ones, magnitude remainder |dividend|) and divZero is tied low.
// ---------------------------------------------------------------------------
module div_seq (
    input  logic clk,
    input  logic reset,
    div_if.slave bus
);
    localparam int DATA_W = 32;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]          state;
    logic [5:0]          cnt;
    logic                sign_a;
    logic                sign_b;
    logic [DATA_W-1:0]   quo;     // holds |dividend| at start, shifts into quotient
    logic [DATA_W-1:0]   rem;
    logic [DATA_W-1:0]   dvs;
    logic [DATA_W-1:0]   hi;
    logic [DATA_W-1:0]   lo;
    logic [DATA_W:0]     rem_shift;
    logic [DATA_W:0]     trial;
    logic                zero_trap;

    function automatic logic [DATA_W-1:0] neg(input logic [DATA_W-1:0] u);
        return (~u) + DATA_W'(1);
    endfunction

    // Two's-complement magnitude; 0x80000000 maps to unsigned 0x80000000.
    function automatic logic [DATA_W-1:0] mag(input logic signed [DATA_W-1:0] v);
        return v[DATA_W-1] ? neg(v) : v;
    endfunction

    // Restoring step: shift next dividend bit into the partial remainder and
    // trial-subtract; the borrow bit decides the quotient bit.
    always_comb begin
        rem_shift = {rem, quo[DATA_W-1]};
        trial     = rem_shift - {1'b0, dvs};
    end

`ifdef DIV_ZERO_EXC_EN
    logic zero_flag;

    assign zero_trap   = (bus.divisor == '0);
    assign bus.divZero = zero_flag;

    // Flag is refreshed on every accept and otherwise held.
    always_ff @(posedge clk) begin
        if (reset) begin
            zero_flag <= 1'b0;
        end else if (state == IDLE && bus.divStart) begin
            zero_flag <= zero_trap;
        end
    end
`else
    assign zero_trap   = 1'b0;
    assign bus.divZero = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            quo    <= '0;
            rem    <= '0;
            dvs    <= '0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.divStart) begin
                        if (zero_trap) begin
                            hi    <= bus.dividend;
                            lo    <= '0;
                            state <= DONE;
                        end else begin
                            sign_a <= bus.dividend[DATA_W-1];
                            sign_b <= bus.divisor[DATA_W-1];
                            quo    <= mag(bus.dividend);
                            dvs    <= mag(bus.divisor);
                            rem    <= '0;
                            cnt    <= '0;
                            state  <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (!trial[DATA_W]) begin
                        rem <= trial[DATA_W-1:0];
                        quo <= {quo[DATA_W-2:0], 1'b1};
                    end else begin
                        rem <= rem_shift[DATA_W-1:0];
                        quo <= {quo[DATA_W-2:0], 1'b0};
                    end
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'd31) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    // Quotient truncates toward zero; remainder follows the dividend.
                    lo    <= (sign_a ^ sign_b) ? neg(quo) : quo;
                    hi    <= sign_a ? neg(rem) : rem;
                    state <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.divBusy = (state == RUN) || (state == FIX);
    assign bus.divDone = (state == DONE);
    assign bus.DivtoHI = hi;
    assign bus.DivtoLO = lo;

endmodule

// File: tb/tb_div_seq.sv
// ---------------------------------------------------------------------------
// tb_div_seq -- directed self-checking bench for div_seq.
// Cycle index c counts falling edges after the accept edge: c=1 is the cycle
// right after the accept edge, so a 34-edge division shows divDone at c=34
// and divBusy for c=1..33.
// ---------------------------------------------------------------------------
module tb_div_seq;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    div_if dif ();

    div_seq u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Results captured by run_div.
    int          d_cyc;
    int          busy_n;
    int          n_done;
    logic        done_next;
    logic [31:0] mid_lo;
    logic [31:0] r_lo;
    logic [31:0] r_hi;
    logic        r_zero;

    // Starts one division and observes a fixed 45-cycle window. Optionally
    // pulses divStart (8 / 2) at cycle pulse_at.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input int pulse_at);
        d_cyc     = 0;
        busy_n    = 0;
        n_done    = 0;
        done_next = 1'b0;
        mid_lo    = '0;
        r_lo      = '0;
        r_hi      = '0;
        r_zero    = 1'b0;
        @(negedge clk);
        dif.dividend = a;
        dif.divisor  = b;
        dif.divStart = 1'b1;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            dif.divStart = 1'b0;
            if (dif.divBusy) busy_n++;
            if (c == 10) mid_lo = dif.DivtoLO;
            if (d_cyc != 0 && c == d_cyc + 1) done_next = dif.divDone;
            if (dif.divDone) begin
                n_done++;
                if (d_cyc == 0) begin
                    d_cyc  = c;
                    r_lo   = dif.DivtoLO;
                    r_hi   = dif.DivtoHI;
                    r_zero = dif.divZero;
                end
            end
            if (c == pulse_at) begin
                dif.divStart = 1'b1;
                dif.dividend = 32'd8;
                dif.divisor  = 32'd2;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        dif.divStart = 1'b1;
        dif.dividend = 32'd100;
        dif.divisor  = 32'd7;
        repeat (3) @(negedge clk);
        checks++; if (dif.divBusy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", dif.divBusy); end
        checks++; if (dif.divDone !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", dif.divDone); end
        checks++; if (dif.DivtoHI !== 32'h0) begin failures++; $display("FAIL reset_hi: got %h expected 00000000", dif.DivtoHI); end
        checks++; if (dif.DivtoLO !== 32'h0) begin failures++; $display("FAIL reset_lo: got %h expected 00000000", dif.DivtoLO); end
        checks++; if (dif.divZero !== 1'b0) begin failures++; $display("FAIL reset_zero: got %b expected 0", dif.divZero); end
        dif.divStart = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_basic();
        run_div(32'd100, 32'd7, 0);
        checks++; if (d_cyc !== 34) begin failures++; $display("FAIL basic_latency: got %0d expected 34", d_cyc); end
        checks++; if (busy_n !== 33) begin failures++; $display("FAIL basic_busy_cycles: got %0d expected 33", busy_n); end
        checks++; if (n_done !== 1) begin failures++; $display("FAIL basic_done_count: got %0d expected 1", n_done); end
        checks++; if (done_next !== 1'b0) begin failures++; $display("FAIL basic_done_width: got %b expected 0", done_next); end
        checks++; if (r_lo !== 32'd14) begin failures++; $display("FAIL basic_lo: got %h expected 0000000e", r_lo); end
        checks++; if (r_hi !== 32'd2) begin failures++; $display("FAIL basic_hi: got %h expected 00000002", r_hi); end
        checks++; if (r_zero !== 1'b0) begin failures++; $display("FAIL basic_zero: got %b expected 0", r_zero); end
        checks++; if (dif.DivtoLO !== 32'd14) begin failures++; $display("FAIL basic_hold_lo: got %h expected 0000000e", dif.DivtoLO); end
    endtask

    task automatic test_signed();
        run_div(32'hFFFF_FF9C, 32'd7, 0);   // -100 / 7
        checks++; if (r_lo !== 32'hFFFF_FFF2) begin failures++; $display("FAIL negdvd_lo: got %h expected fffffff2", r_lo); end
        checks++; if (r_hi !== 32'hFFFF_FFFE) begin failures++; $display("FAIL negdvd_hi: got %h expected fffffffe", r_hi); end
        run_div(32'hFFFF_FFF9, 32'd2, 0);   // -7 / 2
        checks++; if (mid_lo !== 32'hFFFF_FFF2) begin failures++; $display("FAIL hold_during_run: got %h expected fffffff2", mid_lo); end
        checks++; if (r_lo !== 32'hFFFF_FFFD) begin failures++; $display("FAIL neg7_2_lo: got %h expected fffffffd", r_lo); end
        checks++; if (r_hi !== 32'hFFFF_FFFF) begin failures++; $display("FAIL neg7_2_hi: got %h expected ffffffff", r_hi); end
        run_div(32'd100, 32'hFFFF_FFF9, 0); // 100 / -7
        checks++; if (mid_lo !== 32'hFFFF_FFFD) begin failures++; $display("FAIL hold_during_run2: got %h expected fffffffd", mid_lo); end
        checks++; if (r_lo !== 32'hFFFF_FFF2) begin failures++; $display("FAIL negdvs_lo: got %h expected fffffff2", r_lo); end
        checks++; if (r_hi !== 32'd2) begin failures++; $display("FAIL negdvs_hi: got %h expected 00000002", r_hi); end
    endtask

    task automatic test_overflow();
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 0);
        checks++; if (d_cyc !== 34) begin failures++; $display("FAIL ovf_latency: got %0d expected 34", d_cyc); end
        checks++; if (r_lo !== 32'h8000_0000) begin failures++; $display("FAIL ovf_lo: got %h expected 80000000", r_lo); end
        checks++; if (r_hi !== 32'h0) begin failures++; $display("FAIL ovf_hi: got %h expected 00000000", r_hi); end
        checks++; if (r_zero !== 1'b0) begin failures++; $display("FAIL ovf_zero: got %b expected 0", r_zero); end
    endtask

    task automatic test_div_zero();
        run_div(32'd55, 32'd0, 0);
`ifdef DIV_ZERO_EXC_EN
        checks++; if (d_cyc !== 1) begin failures++; $display("FAIL dz_latency: got %0d expected 1", d_cyc); end
        checks++; if (busy_n !== 0) begin failures++; $display("FAIL dz_busy_cycles: got %0d expected 0", busy_n); end
        checks++; if (r_lo !== 32'h0) begin failures++; $display("FAIL dz_lo: got %h expected 00000000", r_lo); end
        checks++; if (r_hi !== 32'd55) begin failures++; $display("FAIL dz_hi: got %h expected 00000037", r_hi); end
        checks++; if (r_zero !== 1'b1) begin failures++; $display("FAIL dz_zero: got %b expected 1", r_zero); end
        checks++; if (dif.divZero !== 1'b1) begin failures++; $display("FAIL dz_zero_hold: got %b expected 1", dif.divZero); end
        run_div(32'd9, 32'd3, 0);
        checks++; if (r_zero !== 1'b0) begin failures++; $display("FAIL dz_zero_clear: got %b expected 0", r_zero); end
        run_div(32'd55, 32'd0, 0);
`else
        checks++; if (d_cyc !== 34) begin failures++; $display("FAIL dz_latency: got %0d expected 34", d_cyc); end
        checks++; if (r_lo !== 32'hFFFF_FFFF) begin failures++; $display("FAIL dz_lo: got %h expected ffffffff", r_lo); end
        checks++; if (r_hi !== 32'd55) begin failures++; $display("FAIL dz_hi: got %h expected 00000037", r_hi); end
        checks++; if (r_zero !== 1'b0) begin failures++; $display("FAIL dz_zero: got %b expected 0", r_zero); end
`endif
    endtask

    task automatic test_reset_mid_run();
        int seen;
        seen = 0;
        @(negedge clk);
        dif.dividend = 32'd100;
        dif.divisor  = 32'd7;
        dif.divStart = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            dif.divStart = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (dif.divBusy !== 1'b0) begin failures++; $display("FAIL abort_busy: got %b expected 0", dif.divBusy); end
        checks++; if (dif.divDone !== 1'b0) begin failures++; $display("FAIL abort_done: got %b expected 0", dif.divDone); end
        checks++; if (dif.DivtoHI !== 32'h0) begin failures++; $display("FAIL abort_hi: got %h expected 00000000", dif.DivtoHI); end
        checks++; if (dif.DivtoLO !== 32'h0) begin failures++; $display("FAIL abort_lo: got %h expected 00000000", dif.DivtoLO); end
        checks++; if (dif.divZero !== 1'b0) begin failures++; $display("FAIL abort_zero: got %b expected 0", dif.divZero); end
        repeat (40) begin
            @(negedge clk);
            if (dif.divDone) seen++;
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL abort_no_done: got %0d pulses expected 0", seen); end
        run_div(32'd9, 32'd3, 0);
        checks++; if (r_lo !== 32'd3) begin failures++; $display("FAIL after_abort_lo: got %h expected 00000003", r_lo); end
        checks++; if (r_hi !== 32'd0) begin failures++; $display("FAIL after_abort_hi: got %h expected 00000000", r_hi); end
    endtask

    task automatic test_ignore_start();
        run_div(32'd100, 32'd7, 5);
        checks++; if (n_done !== 1) begin failures++; $display("FAIL ignore_done_count: got %0d expected 1", n_done); end
        checks++; if (d_cyc !== 34) begin failures++; $display("FAIL ignore_latency: got %0d expected 34", d_cyc); end
        checks++; if (r_lo !== 32'd14) begin failures++; $display("FAIL ignore_lo: got %h expected 0000000e", r_lo); end
        checks++; if (r_hi !== 32'd2) begin failures++; $display("FAIL ignore_hi: got %h expected 00000002", r_hi); end
        checks++; if (dif.divBusy !== 1'b0) begin failures++; $display("FAIL ignore_idle_after: got %b expected 0", dif.divBusy); end
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        reset        = 1'b1;
        dif.divStart = 1'b0;
        dif.dividend = '0;
        dif.divisor  = '0;
        test_reset();
        test_basic();
        test_signed();
        test_overflow();
        test_div_zero();
        test_reset_mid_run();
        test_ignore_start();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
